// File: rtl/dma_psdp_ram_seg_lane.sv
// One segment of the segmented packet-buffer RAM.
//
// Holds the segment's memory array, its byte-enable write port with the
// registered wr_done pulse, and a PIPELINE-deep read response pipeline.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   wr_cmd_be/addr/data       write command payload
//   wr_cmd_valid/ready        write command handshake
//   wr_done                   one-cycle pulse per committed write
//   rd_cmd_addr               read word address
//   rd_cmd_valid/ready        read command handshake
//   rd_resp_data/valid/ready  read response channel (backpressured)
module dma_psdp_ram_seg_lane #(
    parameter int DATA_WIDTH = 128,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 7,
    parameter int PIPELINE   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BE_WIDTH-1:0]   wr_cmd_be,
    input  logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    input  logic [DATA_WIDTH-1:0] wr_cmd_data,
    input  logic                  wr_cmd_valid,
    output logic                  wr_cmd_ready,
    output logic                  wr_done,
    input  logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    input  logic                  rd_cmd_valid,
    output logic                  rd_cmd_ready,
    output logic [DATA_WIDTH-1:0] rd_resp_data,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] mem_q;
    logic                  active;
    logic                  wr_en;
    logic                  rd_accept;
    logic [PIPELINE-1:0]   pipe_valid;
    // stage_ready[k]: stage k may load this cycle (empty, or its contents move on)
    logic [PIPELINE-1:0]   stage_ready;

    // Both command readies come from one register so they drop with reset
    // and rise on the first clock edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= 1'b0;
            wr_done <= 1'b0;
        end else begin
            active  <= 1'b1;
            wr_done <= wr_en;
        end
    end

    assign wr_cmd_ready = active;
    assign wr_en        = wr_cmd_valid && active;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_cmd_be[i]) begin
                    mem[wr_cmd_addr][i*8 +: 8] <= wr_cmd_data[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        stage_ready = '0;
        stage_ready[PIPELINE-1] = !pipe_valid[PIPELINE-1] || rd_resp_ready;
        for (int k = PIPELINE - 2; k >= 0; k--) begin
            stage_ready[k] = !pipe_valid[k] || stage_ready[k+1];
        end
    end

    assign rd_cmd_ready = active && stage_ready[0];
    assign rd_accept    = rd_cmd_valid && rd_cmd_ready;

    // Memory output register: no reset so it maps onto the RAM's own output
    // register. Nonblocking read alongside the write gives read-before-write.
    always_ff @(posedge clk) begin
        if (rd_accept) begin
            mem_q <= mem[rd_cmd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            if (stage_ready[0]) begin
                pipe_valid[0] <= rd_accept;
            end
            for (int k = 1; k < PIPELINE; k++) begin
                if (stage_ready[k]) begin
                    pipe_valid[k] <= pipe_valid[k-1];
                end
            end
        end
    end

    assign rd_resp_valid = pipe_valid[PIPELINE-1];

    generate
        if (PIPELINE == 1) begin : g_direct
            // The RAM output register has no reset, so force zero when empty.
            assign rd_resp_data = pipe_valid[0] ? mem_q : '0;
        end else begin : g_hold
            logic [DATA_WIDTH-1:0] hold_q [1:PIPELINE-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 1; k < PIPELINE; k++) begin
                        hold_q[k] <= '0;
                    end
                end else begin
                    if (stage_ready[1] && pipe_valid[0]) begin
                        hold_q[1] <= mem_q;
                    end
                    for (int k = 2; k < PIPELINE; k++) begin
                        if (stage_ready[k] && pipe_valid[k-1]) begin
                            hold_q[k] <= hold_q[k-1];
                        end
                    end
                end
            end

            assign rd_resp_data = hold_q[PIPELINE-1];
        end
    endgenerate

endmodule

// File: rtl/dma_psdp_ram_seg.sv
// Segmented simple-dual-port RAM: responder side of the DMA engine's
// segmented RAM interface, used as the on-chip packet buffer.
//
// Every segment is an independent lane; segment n uses bit n of each
// valid/ready/done vector and slice n of each address/data/BE bus.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   wr_cmd_be/addr/data       per-segment write command payload
//   wr_cmd_valid/ready        per-segment write handshake
//   wr_done                   per-segment write-committed pulse
//   rd_cmd_addr               per-segment read word address
//   rd_cmd_valid/ready        per-segment read handshake
//   rd_resp_data/valid/ready  per-segment read response channel
module dma_psdp_ram_seg #(
    parameter int SIZE           = 4096,
    parameter int SEG_COUNT      = 2,
    parameter int SEG_DATA_WIDTH = 128,
    parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH / 8,
    parameter int SEG_ADDR_WIDTH = $clog2(SIZE / (SEG_COUNT * SEG_BE_WIDTH)),
    parameter int PIPELINE       = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_be,
    input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] wr_cmd_addr,
    input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] wr_cmd_data,
    input  logic [SEG_COUNT-1:0]                wr_cmd_valid,
    output logic [SEG_COUNT-1:0]                wr_cmd_ready,
    output logic [SEG_COUNT-1:0]                wr_done,
    input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr,
    input  logic [SEG_COUNT-1:0]                rd_cmd_valid,
    output logic [SEG_COUNT-1:0]                rd_cmd_ready,
    output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data,
    output logic [SEG_COUNT-1:0]                rd_resp_valid,
    input  logic [SEG_COUNT-1:0]                rd_resp_ready
);

    generate
        for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
            dma_psdp_ram_seg_lane #(
                .DATA_WIDTH (SEG_DATA_WIDTH),
                .BE_WIDTH   (SEG_BE_WIDTH),
                .ADDR_WIDTH (SEG_ADDR_WIDTH),
                .PIPELINE   (PIPELINE)
            ) u_lane (
                .clk           (clk),
                .rst           (rst),
                .wr_cmd_be     (wr_cmd_be[n*SEG_BE_WIDTH +: SEG_BE_WIDTH]),
                .wr_cmd_addr   (wr_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
                .wr_cmd_data   (wr_cmd_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
                .wr_cmd_valid  (wr_cmd_valid[n]),
                .wr_cmd_ready  (wr_cmd_ready[n]),
                .wr_done       (wr_done[n]),
                .rd_cmd_addr   (rd_cmd_addr[n*SEG_ADDR_WIDTH +: SEG_ADDR_WIDTH]),
                .rd_cmd_valid  (rd_cmd_valid[n]),
                .rd_cmd_ready  (rd_cmd_ready[n]),
                .rd_resp_data  (rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]),
                .rd_resp_valid (rd_resp_valid[n]),
                .rd_resp_ready (rd_resp_ready[n])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dma_psdp_ram_seg.sv
module tb_dma_psdp_ram_seg;

    localparam int SC = 2;
    localparam int DW = 128;
    localparam int BW = 16;
    localparam int AW = 7;

    logic              clk;
    logic              rst;
    logic [SC*BW-1:0]  wr_cmd_be;
    logic [SC*AW-1:0]  wr_cmd_addr;
    logic [SC*DW-1:0]  wr_cmd_data;
    logic [SC-1:0]     wr_cmd_valid;
    logic [SC-1:0]     wr_cmd_ready;
    logic [SC-1:0]     wr_done;
    logic [SC*AW-1:0]  rd_cmd_addr;
    logic [SC-1:0]     rd_cmd_valid;
    logic [SC-1:0]     rd_cmd_ready;
    logic [SC*DW-1:0]  rd_resp_data;
    logic [SC-1:0]     rd_resp_valid;
    logic [SC-1:0]     rd_resp_ready;

    int checks = 0;
    int failures = 0;

    dma_psdp_ram_seg #(
        .SIZE (4096), .SEG_COUNT (SC), .SEG_DATA_WIDTH (DW), .PIPELINE (2)
    ) dut (
        .clk (clk), .rst (rst),
        .wr_cmd_be (wr_cmd_be), .wr_cmd_addr (wr_cmd_addr), .wr_cmd_data (wr_cmd_data),
        .wr_cmd_valid (wr_cmd_valid), .wr_cmd_ready (wr_cmd_ready), .wr_done (wr_done),
        .rd_cmd_addr (rd_cmd_addr), .rd_cmd_valid (rd_cmd_valid), .rd_cmd_ready (rd_cmd_ready),
        .rd_resp_data (rd_resp_data), .rd_resp_valid (rd_resp_valid), .rd_resp_ready (rd_resp_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          seg;
        logic [6:0]  addr;
        logic [127:0] data;
        logic [15:0] be;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int seg, input logic [6:0] addr, input logic [127:0] data,
                            input logic [15:0] be);
        wr_cmd_addr[seg*AW +: AW] = addr;
        wr_cmd_data[seg*DW +: DW] = data;
        wr_cmd_be[seg*BW +: BW]   = be;
        wr_cmd_valid[seg]         = 1'b1;
        check("wr_cmd_ready", wr_cmd_ready[seg], 1'b1);
        step();
        wr_cmd_valid = '0;
        check("wr_done_pulse", wr_done[seg], 1'b1);
        step();
        check("wr_done_single", wr_done[seg], 1'b0);
    endtask

    task automatic do_read(input int seg, input logic [6:0] addr, output logic [127:0] data);
        rd_cmd_addr[seg*AW +: AW] = addr;
        rd_cmd_valid[seg]         = 1'b1;
        #1;
        check("rd_cmd_ready", rd_cmd_ready[seg], 1'b1);
        step();
        rd_cmd_valid = '0;
        check("rd_latency_early", rd_resp_valid[seg], 1'b0);
        step();
        check("rd_latency_valid", rd_resp_valid[seg], 1'b1);
        data = rd_resp_data[seg*DW +: DW];
    endtask

    logic [127:0] rdata;
    int issued, received, occ, bad;
    logic saw_full, cmd_acc, resp_acc;

    initial begin
        vecs[0] = '{0, 7'd5,   128'h0123456789ABCDEF_FEDCBA987654AA55, 16'hFFFF,
                    128'h0123456789ABCDEF_FEDCBA987654AA55};
        vecs[1] = '{1, 7'd5,   128'h00000000_00000000_00000000_00001234, 16'hFFFF,
                    128'h00000000_00000000_00000000_00001234};
        vecs[2] = '{0, 7'd7,   {128{1'b1}}, 16'hFFFF, {128{1'b1}}};
        vecs[3] = '{0, 7'd7,   128'h0, 16'h0001, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00};
        vecs[4] = '{0, 7'd7,   128'h0, 16'h0000, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00};
        vecs[5] = '{1, 7'd127, 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE, 16'hFFFF,
                    128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE};
        vecs[6] = '{1, 7'd0,   128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF,
                    128'h00112233_44556677_8899AABB_CCDDEEFF};
        vecs[7] = '{1, 7'd0,   {128{1'b1}}, 16'hF000, 128'hFFFFFFFF_44556677_8899AABB_CCDDEEFF};
        vecs[8] = '{0, 7'd5,   128'h0, 16'h0000, 128'h0123456789ABCDEF_FEDCBA987654AA55};

        rst = 1'b0;
        wr_cmd_be = '0; wr_cmd_addr = '0; wr_cmd_data = '0; wr_cmd_valid = '0;
        rd_cmd_addr = '0; rd_cmd_valid = '0; rd_resp_ready = '1;
        #1 rst = 1'b1;
        step();
        step();
        check("rst_wr_cmd_ready", wr_cmd_ready, 2'b00);
        check("rst_rd_cmd_ready", rd_cmd_ready, 2'b00);
        check("rst_wr_done", wr_done, 2'b00);
        check("rst_rd_resp_valid", rd_resp_valid, 2'b00);
        check("rst_rd_resp_data", rd_resp_data, 256'h0);
        rst = 1'b0;
        #1;
        check("rel_ready_before_edge", {wr_cmd_ready, rd_cmd_ready}, 4'b0000);
        step();
        check("rel_ready_after_edge", {wr_cmd_ready, rd_cmd_ready}, 4'b1111);

        // Table: write then read back the same location.
        for (int v = 0; v < 9; v++) begin
            do_write(vecs[v].seg, vecs[v].addr, vecs[v].data, vecs[v].be);
            do_read(vecs[v].seg, vecs[v].addr, rdata);
            check($sformatf("vec%0d_data", v), rdata, vecs[v].exp);
        end
        step();

        // Back-to-back writes of addrs 0..15 on seg0.
        for (int i = 0; i < 16; i++) begin
            wr_cmd_addr[0 +: AW] = 7'(i);
            wr_cmd_data[0 +: DW] = {96'h0, 32'hC0DE0000 + 32'(i)};
            wr_cmd_be[0 +: BW]   = 16'hFFFF;
            wr_cmd_valid[0]      = 1'b1;
            step();
            check("b2b_wr_done", wr_done[0], 1'b1);
        end
        wr_cmd_valid = '0;
        step();
        check("b2b_wr_done_end", wr_done[0], 1'b0);

        // Streaming 16 reads with the response stalled for cycles 3..8.
        issued = 0; received = 0; occ = 0; saw_full = 1'b0;
        for (int cyc = 0; cyc < 80 && received < 16; cyc++) begin
            rd_resp_ready[0]   = !(cyc >= 3 && cyc <= 8);
            rd_cmd_valid[0]    = (issued < 16);
            rd_cmd_addr[0 +: AW] = 7'(issued);
            #1;
            check("stream_cmd_ready", rd_cmd_ready[0], (occ < 2) || rd_resp_ready[0]);
            if (!rd_cmd_ready[0]) saw_full = 1'b1;
            if (!rd_resp_ready[0]) check("stall_valid", rd_resp_valid[0], 1'b1);
            if (rd_resp_valid[0])
                check("stream_data", rd_resp_data[0 +: DW], {96'h0, 32'hC0DE0000 + 32'(received)});
            cmd_acc  = rd_cmd_valid[0] && rd_cmd_ready[0];
            resp_acc = rd_resp_valid[0] && rd_resp_ready[0];
            if (resp_acc) received++;
            if (cmd_acc) issued++;
            occ = occ + int'(cmd_acc) - int'(resp_acc);
            step();
        end
        rd_cmd_valid = '0;
        rd_resp_ready = '1;
        check("stream_count", 32'(received), 32'd16);
        check("stream_saw_full", saw_full, 1'b1);

        // Same-cycle write and read of seg1 addr 3.
        do_write(1, 7'd3, 128'h11, 16'hFFFF);
        wr_cmd_addr[AW +: AW] = 7'd3;
        wr_cmd_data[DW +: DW] = 128'h22;
        wr_cmd_be[BW +: BW]   = 16'hFFFF;
        wr_cmd_valid[1]       = 1'b1;
        rd_cmd_addr[AW +: AW] = 7'd3;
        rd_cmd_valid[1]       = 1'b1;
        step();
        wr_cmd_valid = '0;
        check("coll_wr_done", wr_done[1], 1'b1);
        // Read issued in the wr_done cycle must see the new data.
        step();
        rd_cmd_valid = '0;
        check("coll_old_valid", rd_resp_valid[1], 1'b1);
        check("coll_old_data", rd_resp_data[DW +: DW], 128'h11);
        step();
        check("coll_new_valid", rd_resp_valid[1], 1'b1);
        check("coll_new_data", rd_resp_data[DW +: DW], 128'h22);
        step();

        // Reset with two reads in flight and a write in the last cycle.
        rd_cmd_addr[0 +: AW] = 7'd0;
        rd_cmd_valid[0] = 1'b1;
        step();
        rd_cmd_addr[0 +: AW] = 7'd1;
        wr_cmd_addr[AW +: AW] = 7'd9;
        wr_cmd_data[DW +: DW] = 128'h99;
        wr_cmd_be[BW +: BW]   = 16'hFFFF;
        wr_cmd_valid[1] = 1'b1;
        step();
        rd_cmd_valid = '0;
        wr_cmd_valid = '0;
        rst = 1'b1;
        #1;
        check("mid_rst_resp_valid", rd_resp_valid, 2'b00);
        check("mid_rst_resp_data", rd_resp_data, 256'h0);
        check("mid_rst_wr_done", wr_done, 2'b00);
        check("mid_rst_cmd_ready", {wr_cmd_ready, rd_cmd_ready}, 4'b0000);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_rst_ready", {wr_cmd_ready, rd_cmd_ready}, 4'b1111);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rd_resp_valid != 2'b00 || wr_done != 2'b00) bad++;
            step();
        end
        check("post_rst_no_stale", 32'(bad), 32'd0);
        do_read(1, 7'd9, rdata);
        check("post_rst_wr_kept", rdata, 128'h99);
        do_read(0, 7'd0, rdata);
        check("post_rst_mem_kept", rdata, {96'h0, 32'hC0DE0000});
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_psdp_ram_seg.md
# dma_psdp_ram_seg

Segmented simple-dual-port RAM that is the responder side of the DMA engine's segmented RAM interface. It accepts per-segment write commands, which are what the AXI read path issues, and returns `wr_done`. It accepts per-segment read commands, which are what the AXI write path issues, and returns data through a backpressured, pipelined response channel. It sits behind the RAM select mux as the on-chip packet buffer for the DMA engine.

## Interface
- `SIZE`, 4096: total capacity in bytes.
- `SEG_COUNT`, 2: number of independent segments.
- `SEG_DATA_WIDTH`, 128: data bits per segment.
- `SEG_BE_WIDTH`, `SEG_DATA_WIDTH/8`: byte enables per segment.
- `SEG_ADDR_WIDTH`, `$clog2(SIZE/(SEG_COUNT*SEG_BE_WIDTH))`: word address bits per segment.
- `PIPELINE`, 2: read latency in cycles; minimum 1.

Ports are listed as name, direction, width, meaning.
- Clock and reset (already decided): one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `wr_cmd_be` in `SEG_COUNT*SEG_BE_WIDTH`: per-segment byte enables.
- `wr_cmd_addr` in `SEG_COUNT*SEG_ADDR_WIDTH`: per-segment word address.
- `wr_cmd_data` in `SEG_COUNT*SEG_DATA_WIDTH`: per-segment write data.
- `wr_cmd_valid` in `SEG_COUNT`: write command valid.
- `wr_cmd_ready` out `SEG_COUNT`: write command ready.
- `wr_done` out `SEG_COUNT`: one-cycle pulse per committed write.
- `rd_cmd_addr` in `SEG_COUNT*SEG_ADDR_WIDTH`: per-segment read word address.
- `rd_cmd_valid` in `SEG_COUNT`: read command valid.
- `rd_cmd_ready` out `SEG_COUNT`: read command ready.
- `rd_resp_data` out `SEG_COUNT*SEG_DATA_WIDTH`: read data.
- `rd_resp_valid` out `SEG_COUNT`: read data valid.
- `rd_resp_ready` in `SEG_COUNT`: read data ready.

## Operation
- Segments are fully independent. Segment n uses bit n of each valid/ready/done vector and slice n of each data/address/BE bus.
- Write path:
  - `wr_cmd_ready[n]` is 1 whenever the block is not in reset.
  - On `valid && ready`, each byte with `be=1` is written at `addr`; bytes with `be=0` are untouched.
  - An all-zero BE still counts as a write and still produces `wr_done`.
- Read path: a `PIPELINE`-deep valid/data shift pipeline per segment.
  - Stage 0 is the memory output register; stages 1..`PIPELINE`-1 are holding registers; the last stage drives `rd_resp_*`.
  - Stage k advances when stage k+1 is empty or stage k+1 is advancing.
  - The last stage advances when `rd_resp_ready=1`.
  - `rd_cmd_ready[n] = !valid[0] || advance[0]`, a combinational function of `rd_resp_ready` through the chain.
  - Responses return in command order. No command is ever dropped or duplicated.
- Same-segment, same-address read and write accepted in the same cycle: the read returns the old data (read-before-write).
- Addresses span exactly 2^`SEG_ADDR_WIDTH` words, so there is no out-of-range case.
- Memory contents are not initialised and are not cleared by reset.

## Timing
- Reset values: `wr_cmd_ready=0`, `rd_cmd_ready=0`, `wr_done=0`, `rd_resp_valid=0`, `rd_resp_data=0`. All pipeline valid bits are cleared.
- `wr_done[n]` is registered: it asserts exactly 1 cycle after the write handshake, for 1 cycle.
  - Back-to-back writes produce back-to-back pulses.
  - `wr_done` asserts only after the data is readable: a read accepted in the same cycle as `wr_done` returns the new data.
- Read latency is `PIPELINE` cycles from the `rd_cmd` handshake to `rd_resp_valid` when unstalled.
- Throughput is 1 read per cycle per segment with `rd_resp_ready` held high.
- While `rd_resp_valid && !rd_resp_ready`, `rd_resp_data` is held stable.
- Full pipeline (all `PIPELINE` stages valid, output stalled): `rd_cmd_ready=0`.
- Releasing `rd_resp_ready` does the following in the same cycle:
  - The pipeline advances.
  - `rd_cmd_ready` rises combinationally.
- Reset asserted mid-operation:
  - In-flight reads are discarded with no response.
  - A write handshaken in the cycle before reset still commits to memory, but its `wr_done` is suppressed.
- After reset deasserts, `wr_cmd_ready` and `rd_cmd_ready` assert on the first clock edge.

## Structure
- No shared package. All widths derive from the module parameters.
- One sub-module, `dma_psdp_ram_seg_lane`, holding one segment's memory array, write logic, `wr_done` register and read pipeline. The top instantiates it `SEG_COUNT` times in a generate loop and slices the buses.
- Memory is inferred as simple-dual-port block RAM with byte-write enables.

## Test plan
- Write/readback:
  - Stimulus: seg0 write addr 5, data `0x..AA55`, `be=all1`; seg1 write addr 5, data `0x..1234`; then read addr 5 on both segments.
  - Required response: `wr_done` pulses 1 cycle after each handshake; reads return `0x..AA55` and `0x..1234` after exactly 2 cycles.
- Partial BE:
  - Stimulus: write addr 7 with all `0xFF`; then write `0x00` with `be=0x0001`; then read addr 7.
  - Required response: byte 0 reads `0x00`, all other bytes read `0xFF`.
- Streaming and backpressure:
  - Stimulus: 16 back-to-back reads of addrs 0–15; hold `rd_resp_ready=0` for cycles 3–8.
  - Required response: `rd_cmd_ready` deasserts once 2 responses are held; all 16 responses are in order with no loss; data is stable throughout the stall.
- Same-cycle collision:
  - Stimulus: addr 3 holds `0x11`; in one cycle, write `0x22` to addr 3 and read addr 3.
  - Required response: the read returns `0x11`; a following read returns `0x22`.
- Reset mid-stream:
  - Stimulus: assert `rst` with 2 reads in flight.
  - Required response: `rd_resp_valid=0` immediately and no stale responses after release; memory data written before reset reads back intact.
